// File: rtl/serial_add_sequencer_if.sv
// rtl/serial_add_sequencer_if.sv - host and serial-adder signal bundle for serial_add_sequencer
//
// Purpose: groups the operand handshake, the result outputs and the serial
// adder control pins of serial_add_sequencer into one bundle.
//   slave  : the sequencer side (drives InReady, adder controls, Result).
//   master : the environment side (host offering operands, adder returning ResultIn).
// Signals:
//   InValid/InReady        operand pair handshake
//   OperandData, CoeffIn   operands; OperandData is serialized, CoeffIn is parallel-loaded
//   AdderResetN, ParaLoad, CoeffData, SerialIn, EnableShiftAdd   adder control/data pins
//   ResultIn               adder parallel output
//   Result, ResultValid    captured sum and its one-cycle strobe
//   BitCount               index of the bit currently on SerialIn
interface serial_add_sequencer_if #(
  parameter int WIDTH = 8
);
  logic                       InValid;
  logic                       InReady;
  logic [WIDTH-1:0]           OperandData;
  logic [WIDTH-1:0]           CoeffIn;
  logic                       AdderResetN;
  logic                       ParaLoad;
  logic [WIDTH-1:0]           CoeffData;
  logic                       SerialIn;
  logic                       EnableShiftAdd;
  logic [WIDTH-1:0]           ResultIn;
  logic [WIDTH-1:0]           Result;
  logic                       ResultValid;
  logic [$clog2(WIDTH)-1:0]   BitCount;

  modport master (
    output InValid, OperandData, CoeffIn, ResultIn,
    input  InReady, AdderResetN, ParaLoad, CoeffData, SerialIn,
           EnableShiftAdd, Result, ResultValid, BitCount
  );

  modport slave (
    input  InValid, OperandData, CoeffIn, ResultIn,
    output InReady, AdderResetN, ParaLoad, CoeffData, SerialIn,
           EnableShiftAdd, Result, ResultValid, BitCount
  );
endinterface

// File: rtl/serial_add_sequencer.sv
// rtl/serial_add_sequencer.sv - transmit-side sequencer for the bit-serial adder
//
// Purpose: accepts one operand pair per InValid/InReady handshake, clears the
// adder and loads its coefficient, streams OperandData LSB-first for WIDTH
// cycles with EnableShiftAdd, then captures ResultIn into Result with a
// one-cycle ResultValid pulse. Every output comes straight from a register.
// Ports:
//   Clock  sole clock, rising edge
//   Reset  synchronous, active-high
//   bus    serial_add_sequencer_if.slave (handshake, adder pins, result)
module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                    Clock,
  input  logic                    Reset,
  serial_add_sequencer_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    Idle,
    Load,
    Shift,
    Capture
  } stateT;

  stateT            state;
  logic [WIDTH-1:0] shiftReg;

  logic             inReady;
  logic             adderResetN;
  logic             paraLoad;
  logic [WIDTH-1:0] coeffData;
  logic             serialIn;
  logic             enableShiftAdd;
  logic [WIDTH-1:0] result;
  logic             resultValid;
  logic [CW-1:0]    bitCount;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state          <= Idle;
      shiftReg       <= '0;
      inReady        <= 1'b1;
      adderResetN    <= 1'b0;
      paraLoad       <= 1'b0;
      coeffData      <= '0;
      serialIn       <= 1'b0;
      enableShiftAdd <= 1'b0;
      result         <= '0;
      resultValid    <= 1'b0;
      bitCount       <= '0;
    end else begin
      // Pulse-type outputs default low/inactive; states re-assert them.
      resultValid <= 1'b0;
      adderResetN <= 1'b1;
      paraLoad    <= 1'b0;
      case (state)
        Idle: begin
          if (bus.InValid && inReady) begin
            shiftReg    <= bus.OperandData;
            coeffData   <= bus.CoeffIn;
            inReady     <= 1'b0;
            // Clear and load coincide: the adder drops its stale carry and
            // takes the new coefficient on the same edge.
            adderResetN <= 1'b0;
            paraLoad    <= 1'b1;
            state       <= Load;
          end
        end
        Load: begin
          // First serial bit is presented together with the enable.
          enableShiftAdd <= 1'b1;
          serialIn       <= shiftReg[0];
          shiftReg       <= {1'b0, shiftReg[WIDTH-1:1]};
          bitCount       <= '0;
          state          <= Shift;
        end
        Shift: begin
          if (bitCount == LastBit) begin
            enableShiftAdd <= 1'b0;
            serialIn       <= 1'b0;
            bitCount       <= '0;
            state          <= Capture;
          end else begin
            serialIn <= shiftReg[0];
            shiftReg <= {1'b0, shiftReg[WIDTH-1:1]};
            bitCount <= bitCount + 1'b1;
          end
        end
        Capture: begin
          result      <= bus.ResultIn;
          resultValid <= 1'b1;
          inReady     <= 1'b1;
          state       <= Idle;
        end
        default: state <= Idle;
      endcase
    end
  end

  assign bus.InReady        = inReady;
  assign bus.AdderResetN    = adderResetN;
  assign bus.ParaLoad       = paraLoad;
  assign bus.CoeffData      = coeffData;
  assign bus.SerialIn       = serialIn;
  assign bus.EnableShiftAdd = enableShiftAdd;
  assign bus.Result         = result;
  assign bus.ResultValid    = resultValid;
  assign bus.BitCount       = bitCount;
endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb/tb_serial_add_sequencer.sv - bench for serial_add_sequencer at WIDTH 8 and 4
//
// Purpose: drives two sequencer instances (WIDTH=8 and WIDTH=4), each wired to
// a behavioural bit-serial adder, compares every output each cycle against a
// frame timeline model, and checks hand-computed results and latencies.
module tb_serial_add_sequencer;
  logic       Clock;
  logic       Reset;
  int         cyc = 0;
  int         compared = 0;
  int         mismatched = 0;

  logic       inValid [2];
  logic [7:0] opIn    [2];
  logic [7:0] coefIn  [2];
  logic       readyObs[2];

  int         rvCount [2] = '{0, 0};
  int         rvCycLog[2][32];
  logic [7:0] rvValLog[2][32];
  logic [7:0] serBits [2];
  int         enCount [2];

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : gUnit
    localparam int W = (gi == 0) ? 8 : 4;

    serial_add_sequencer_if #(.WIDTH(W)) bus ();

    serial_add_sequencer #(.WIDTH(W)) dut (
      .Clock(Clock),
      .Reset(Reset),
      .bus  (bus.slave)
    );

    assign bus.InValid     = inValid[gi];
    assign bus.OperandData = opIn[gi][W-1:0];
    assign bus.CoeffIn     = coefIn[gi][W-1:0];
    assign readyObs[gi]    = bus.InReady;

    // Behavioural bit-serial adder the sequencer talks to.
    logic [W-1:0] acc;
    logic [W-1:0] coefSh;
    logic         carry;
    always @(posedge Clock) begin
      if (!bus.AdderResetN) begin
        acc   <= '0;
        carry <= 1'b0;
      end else if (bus.EnableShiftAdd) begin
        acc    <= {bus.SerialIn ^ coefSh[0] ^ carry, acc[W-1:1]};
        carry  <= (bus.SerialIn & coefSh[0]) | (carry & (bus.SerialIn ^ coefSh[0]));
        coefSh <= coefSh >> 1;
      end
      if (bus.ParaLoad) coefSh <= bus.CoeffData;
    end
    assign bus.ResultIn = acc;

    // Frame timeline model: d is the offset of the current cycle from the accept cycle.
    bit           live = 0;
    bit           active = 0;
    bit           rstCycle = 0;
    int           d = 0;
    logic [W-1:0] mOp = '0;
    logic [W-1:0] mCoef = '0;
    logic [W-1:0] mRes = '0;

    initial begin
      forever begin
        @(posedge Clock);
        live = 1;
        if (Reset) begin
          active   = 0;
          d        = 0;
          mRes     = '0;
          mCoef    = '0;
          rstCycle = 1;
        end else begin
          rstCycle = 0;
          if (bus.InValid && !(active && d >= 1 && d <= W + 2)) begin
            active = 1;
            d      = 1;
            mOp    = bus.OperandData;
            mCoef  = bus.CoeffIn;
          end else if (active) begin
            if (d >= W + 3) active = 0;
            else begin
              d = d + 1;
              if (d == W + 3) mRes = W'((mOp + mCoef) % (1 << W));
            end
          end
        end
      end
    end

    initial begin
      bit inShift;
      serBits[gi] = '0;
      enCount[gi] = 0;
      forever begin
        @(negedge Clock);
        if (live) begin
          inShift = active && d >= 2 && d <= W + 1;
          check($sformatf("w%0d_InReady", W), bus.InReady, !(active && d >= 1 && d <= W + 2));
          check($sformatf("w%0d_AdderResetN", W), bus.AdderResetN, !(rstCycle || (active && d == 1)));
          check($sformatf("w%0d_ParaLoad", W), bus.ParaLoad, active && d == 1);
          check($sformatf("w%0d_EnableShiftAdd", W), bus.EnableShiftAdd, inShift);
          check($sformatf("w%0d_ResultValid", W), bus.ResultValid, active && d == W + 3);
          check($sformatf("w%0d_Result", W), bus.Result, mRes);
          check($sformatf("w%0d_CoeffData", W), bus.CoeffData, mCoef);
          if (inShift) begin
            check($sformatf("w%0d_SerialIn", W), bus.SerialIn, mOp[d-2]);
            check($sformatf("w%0d_BitCount", W), bus.BitCount, d - 2);
          end
          if (rstCycle) begin
            check($sformatf("w%0d_rst_SerialIn", W), bus.SerialIn, 0);
            check($sformatf("w%0d_rst_BitCount", W), bus.BitCount, 0);
          end
        end
        // Event log for the directed checks.
        if (bus.ResultValid && rvCount[gi] < 32) begin
          rvCycLog[gi][rvCount[gi]] = cyc;
          rvValLog[gi][rvCount[gi]] = 8'(bus.Result);
          rvCount[gi]++;
        end
        if (bus.ParaLoad) enCount[gi] = 0;
        if (bus.EnableShiftAdd) begin
          enCount[gi]++;
          serBits[gi] = {bus.SerialIn, serBits[gi][7:1]};
        end
      end
    end
  end

  // Offer a pair on unit u, hold InValid until accepted; k returns the accept cycle.
  task automatic offer(input int u, input logic [7:0] op, input logic [7:0] cf, output int k);
    inValid[u] = 1'b1;
    opIn[u]    = op;
    coefIn[u]  = cf;
    k          = -1;
    for (int n = 0; n < 40; n++) begin
      if (readyObs[u]) begin
        k = cyc;
        @(posedge Clock);
        #1;
        inValid[u] = 1'b0;
        return;
      end
      @(negedge Clock);
    end
    inValid[u] = 1'b0;
    compared++;
    mismatched++;
    $display("FAIL offer_timeout: unit %0d never ready, required ready within 40 cycles", u);
  endtask

  initial begin
    int k, k2, k3, base;
    Reset = 1'b1;
    for (int u = 0; u < 2; u++) begin
      inValid[u] = 1'b0;
      opIn[u]    = '0;
      coefIn[u]  = '0;
    end
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);

    // Basic sum
    base = rvCount[0];
    offer(0, 8'h35, 8'h4A, k);
    repeat (12) @(negedge Clock);
    check("basic_count", rvCount[0] - base, 1);
    check("basic_result", rvValLog[0][base], 8'h7F);
    check("basic_latency", rvCycLog[0][base] - k, 11);
    check("basic_serial_bits", serBits[0], 8'h35);

    // Carry flush, second pair accepted in the ResultValid cycle
    base = rvCount[0];
    offer(0, 8'hFF, 8'h01, k);
    offer(0, 8'h01, 8'h01, k2);
    repeat (12) @(negedge Clock);
    check("flush_count", rvCount[0] - base, 2);
    check("flush_result0", rvValLog[0][base], 8'h00);
    check("flush_result1", rvValLog[0][base+1], 8'h02);
    check("flush_reaccept", k2 - k, 11);

    // Back-to-back with InValid held
    base = rvCount[0];
    offer(0, 8'h10, 8'h01, k);
    offer(0, 8'h20, 8'h02, k2);
    offer(0, 8'h30, 8'h03, k3);
    repeat (12) @(negedge Clock);
    check("b2b_count", rvCount[0] - base, 3);
    check("b2b_result0", rvValLog[0][base], 8'h11);
    check("b2b_result1", rvValLog[0][base+1], 8'h22);
    check("b2b_result2", rvValLog[0][base+2], 8'h33);
    check("b2b_spacing0", rvCycLog[0][base+1] - rvCycLog[0][base], 11);
    check("b2b_spacing1", rvCycLog[0][base+2] - rvCycLog[0][base+1], 11);

    // Busy ignore: pulse during SHIFT
    base = rvCount[0];
    offer(0, 8'h12, 8'h34, k);
    repeat (4) @(negedge Clock);
    inValid[0] = 1'b1;
    opIn[0]    = 8'hAA;
    coefIn[0]  = 8'h55;
    @(negedge Clock);
    inValid[0] = 1'b0;
    repeat (12) @(negedge Clock);
    check("busy_count", rvCount[0] - base, 1);
    check("busy_result", rvValLog[0][base], 8'h46);

    // Reset mid-frame at BitCount 3
    base = rvCount[0];
    offer(0, 8'h12, 8'h34, k);
    repeat (5) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    repeat (14) @(negedge Clock);
    check("abort_count", rvCount[0] - base, 0);
    base = rvCount[0];
    offer(0, 8'h0F, 8'hF0, k);
    repeat (12) @(negedge Clock);
    check("post_reset_count", rvCount[0] - base, 1);
    check("post_reset_result", rvValLog[0][base], 8'hFF);

    // WIDTH=4 unit
    base = rvCount[1];
    offer(1, 8'h09, 8'h08, k);
    repeat (10) @(negedge Clock);
    check("w4_count", rvCount[1] - base, 1);
    check("w4_result", rvValLog[1][base], 8'h01);
    check("w4_latency", rvCycLog[1][base] - k, 7);
    check("w4_enable_cycles", enCount[1], 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/serial_add_sequencer.md
# serial_add_sequencer

Transmit-side controller for the bit-serial adder datapath. It accepts one operand pair per valid/ready handshake and drives the adder's control and serial-data pins: clear, coefficient load, then WIDTH LSB-first serial bits with shift enable. It captures the adder's parallel result and presents it with a one-cycle valid pulse. It sits between the host/register interface and the serial adder; each of its outputs ties directly to the adder input of the same name.

## Interface

- WIDTH, 8, operand/result width; also the serial frame length in bits (≥2)

- Clock  in  1  sole clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high; sampled on rising Clock
- InValid  in  1  operand pair offered
- InReady  out  1  sequencer idle, can accept
- OperandData  in  WIDTH  operand serialized onto SerialIn
- CoeffIn  in  WIDTH  operand forwarded to adder's parallel load
- AdderResetN  out  1  active-low clear to adder (clears shift regs and held carry)
- ParaLoad  out  1  adder coefficient load strobe
- CoeffData  out  WIDTH  coefficient value to adder
- SerialIn  out  1  serial operand bit, LSB first
- EnableShiftAdd  out  1  adder shift/accumulate enable
- ResultIn  in  WIDTH  adder ParallelOut
- Result  out  WIDTH  captured sum
- ResultValid  out  1  one-cycle pulse, Result updated
- BitCount  out  $clog2(WIDTH)  index of bit currently on SerialIn

## Operation

- All outputs are Moore: decoded from registered state or driven from registers, no input-to-output combinational paths.
- **IDLE**
  - InReady=1.
  - On InValid&&InReady: latch OperandData into the serial register and CoeffIn into CoeffData; go to LOAD.
- **LOAD** (1 cycle)
  - AdderResetN=0 (falls at cycle start, clearing adder regs and carry before the edge).
  - ParaLoad=1, with CoeffData stable.
  - Go to SHIFT, BitCount=0.
- **SHIFT** (WIDTH cycles)
  - EnableShiftAdd=1; SerialIn = serial register bit 0.
  - Each edge: serial register shifts right (MSB fill 0), BitCount+1.
  - After BitCount==WIDTH-1, go to CAPTURE.
- **CAPTURE** (1 cycle)
  - All adder controls idle; ResultIn is now final.
  - Edge: Result<=ResultIn, ResultValid<=1; go to IDLE.
- Arithmetic: Result = (OperandData + CoeffIn) mod 2^WIDTH. The final carry is discarded. No carry leaks into the next frame, because every frame starts with an AdderResetN pulse.
- InValid outside IDLE is ignored; the data is not latched and not queued.
- OperandData/CoeffIn are don't-care after the accept edge.
- Reset values, held while Reset=1: state IDLE, InReady=1 from the first post-reset cycle, AdderResetN=0, ParaLoad=0, EnableShiftAdd=0, SerialIn=0, CoeffData=0, Result=0, ResultValid=0, BitCount=0.
  - AdderResetN returns to 1 the cycle after Reset deasserts.
- Reset mid-frame (any state): abort immediately to reset values. No ResultValid is issued for the aborted frame.

## Timing

- Accept edge at cycle k.
  - LOAD occupies k+1.
  - SHIFT occupies k+2 .. k+WIDTH+1.
  - CAPTURE occupies k+WIDTH+2.
  - ResultValid is high in cycle k+WIDTH+3, concurrent with InReady=1.
- Latency from accept to ResultValid: WIDTH+3 cycles. Throughput: one frame per WIDTH+3 cycles when InValid is held.
- A new accept may occur in the same cycle as ResultValid.
- ResultValid is exactly 1 cycle wide. Result holds until the next capture or Reset.
- EnableShiftAdd is high for exactly WIDTH consecutive cycles per frame. ParaLoad is high exactly 1 cycle, never overlapping EnableShiftAdd.

## Test plan

- **Basic sum:** WIDTH=8, offer 0x35/0x4A once -> ParaLoad pulse at k+1, SerialIn sequence 1,0,1,0,1,1,0,0 over k+2..k+9, Result=0x7F with ResultValid at k+11.
- **Carry flush:** 0xFF+0x01 -> Result=0x00; immediately following 0x01+0x01 -> Result=0x02 (no stale carry).
- **Back-to-back:** InValid held high with 3 pairs (0x10/0x01, 0x20/0x02, 0x30/0x03) -> Results 0x11, 0x22, 0x33, ResultValid pulses spaced exactly 11 cycles.
- **Busy ignore:** InValid pulsed with 0xAA/0x55 during SHIFT -> no second frame, InReady stays 0, only the first result appears.
- **Reset mid-frame:** assert Reset for 1 cycle at BitCount=3 -> all outputs to reset values next cycle, no ResultValid. A following 0x0F+0xF0 gives Result=0xFF.
- **Parameter:** WIDTH=4, 0x9+0x8 -> Result=0x1, ResultValid at k+7, EnableShiftAdd high exactly 4 cycles.
